fir_mac_param: RTL and testbench

Parametrised, runtime-reloadable FIR filter core with a single time-multiplexed multiply-accumulate (MAC) unit. It filters signed ADC samples using `TAPS` coefficients. Coefficients arrive serially (from the UART receive path) into a shadow bank, and the shadow bank is committed to the active bank only between samples, so no output ever mixes old and new coefficients. The core sits between the ADC sample interface and the FIFO write path, in the ADC clock domain.

---
 rtl/fir_mac_param.sv | 199 +++++++++++++++++++
 tb/tb_fir_mac_param.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_param.sv
// fir_mac_param: runtime-reloadable FIR filter built around one shared MAC.
// Samples are accepted into a delay line, then TAPS products are accumulated
// one per clock. Coefficients are loaded serially into a shadow bank and
// copied to the active bank only while the MAC is idle. That way no output
// ever mixes coefficients from the old bank and the new bank.
module fir_mac_param #(
    parameter int TAPS   = 16,
    parameter int DATA_W = 12,
    parameter int COEF_W = 12,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     en_fir_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic                     sample_valid_i,
    output logic                     overrun_o,
    output logic signed [OUT_W-1:0]  data_o,
    output logic                     data_valid_o,
    output logic                     sat_o,
    input  logic                     load_start_i,
    input  logic signed [COEF_W-1:0] coef_i,
    input  logic                     coef_valid_i,
    output logic                     load_active_o,
    output logic                     load_done_o
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int EXT_W  = ACC_W + OUT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic signed [EXT_W-1:0] MAX_V =
        $signed({{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [EXT_W-1:0] MIN_V =
        $signed({{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
    localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1) << SHIFT;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} mac_state_t;
    typedef enum logic [1:0] {L_IDLE, L_LOAD, L_COMMIT} load_state_t;

    // Apply the arithmetic scale-down, then clamp into the output range.
    // The result is packed as {sat, data}.
    function automatic logic [OUT_W:0] shift_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        logic signed [EXT_W-1:0] ext;
        sh  = acc >>> SHIFT;
        ext = EXT_W'(sh);
        if (ext > MAX_V) begin
            return {1'b1, MAX_V[OUT_W-1:0]};
        end else if (ext < MIN_V) begin
            return {1'b1, MIN_V[OUT_W-1:0]};
        end
        return {1'b0, ext[OUT_W-1:0]};
    endfunction

    mac_state_t                 state_q, state_d;
    load_state_t                lstate_q, lstate_d;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           ptr_q, ptr_d;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [DATA_W-1:0]   x_q      [TAPS];
    logic signed [COEF_W-1:0]   act_q    [TAPS];
    logic signed [COEF_W-1:0]   shadow_q [TAPS];
    logic signed [OUT_W-1:0]    data_q;
    logic                       sat_q;
    logic                       dv_q;
    logic                       ovr_q;
    logic                       ldone_q;
    logic                       shadow_we;
    logic                       commit;
    logic                       strobe;
    logic signed [PROD_W-1:0]   prod;

    assign strobe        = sample_valid_i && en_fir_i;
    assign commit        = (lstate_q == L_COMMIT) && !load_start_i && (state_q == S_IDLE);
    assign data_o        = data_q;
    assign sat_o         = sat_q;
    assign data_valid_o  = dv_q;
    assign overrun_o     = ovr_q;
    assign load_done_o   = ldone_q;
    assign load_active_o = (lstate_q != L_IDLE);

    // Product of the current tap, sign-extended before multiplication.
    always_comb begin
        prod = '0;
        prod = PROD_W'(x_q[idx_q]) * PROD_W'(act_q[idx_q]);
    end

    // MAC sequencer state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // MAC sequencer: accept a sample, run TAPS products, then emit one result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (strobe) state_d = S_MAC;
            S_MAC:   if (idx_q == LAST_IDX) state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: delay line, accumulator, tap index and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            sat_q  <= 1'b0;
            dv_q   <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            dv_q  <= 1'b0;
            ovr_q <= strobe && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (strobe) begin
                        for (int k = TAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
                        x_q[0] <= sample_i;
                        acc_q  <= '0;
                        idx_q  <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + ACC_W'(prod);
                    idx_q <= idx_q + 1'b1;
                end
                S_OUT: begin
                    {sat_q, data_q} <= shift_sat(acc_q);
                    dv_q            <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Coefficient loader state and write-pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lstate_q <= L_IDLE;
            ptr_q    <= '0;
        end else begin
            lstate_q <= lstate_d;
            ptr_q    <= ptr_d;
        end
    end

    // Coefficient loader: a start pulse always restarts at index 0 and cancels
    // any pending commit. A complete bank waits for the MAC to go idle.
    always_comb begin
        lstate_d  = lstate_q;
        ptr_d     = ptr_q;
        shadow_we = 1'b0;
        if (load_start_i) begin
            lstate_d = L_LOAD;
            ptr_d    = '0;
        end else begin
            case (lstate_q)
                L_LOAD: begin
                    if (coef_valid_i) begin
                        shadow_we = 1'b1;
                        if (ptr_q == LAST_IDX) begin
                            lstate_d = L_COMMIT;
                            ptr_d    = '0;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                L_COMMIT: if (state_q == S_IDLE) lstate_d = L_IDLE;
                default: ;
            endcase
        end
    end

    // Shadow and active coefficient banks. The active bank resets to pass-through.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < TAPS; k++) begin
                shadow_q[k] <= '0;
                act_q[k]    <= (k == 0) ? UNITY : '0;
            end
            ldone_q <= 1'b0;
        end else begin
            ldone_q <= commit;
            if (shadow_we) shadow_q[ptr_q] <= coef_i;
            if (commit) begin
                for (int k = 0; k < TAPS; k++) act_q[k] <= shadow_q[k];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_param.sv
// Testbench for fir_mac_param. A cycle-level reference model observes the
// inputs at each clock edge and pushes the expected results into a scoreboard.
// A separate monitor compares the DUT outputs against that scoreboard.
module tb_fir_mac_param;

    localparam int TAPS   = 16;
    localparam int DATA_W = 12;
    localparam int COEF_W = 12;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 10;
    localparam longint MAXO = (64'sd1 <<< (OUT_W - 1)) - 1;
    localparam longint MINO = -(64'sd1 <<< (OUT_W - 1));

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_fir = 1'b0;
    logic sample_valid = 1'b0;
    logic coef_valid = 1'b0;
    logic load_start = 1'b0;
    logic signed [DATA_W-1:0] sample = '0;
    logic signed [COEF_W-1:0] coef = '0;
    logic overrun_o, data_valid_o, sat_o, load_active_o, load_done_o;
    logic signed [OUT_W-1:0] data_o;

    fir_mac_param #(
        .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_fir_i(en_fir),
        .sample_i(sample), .sample_valid_i(sample_valid), .overrun_o(overrun_o),
        .data_o(data_o), .data_valid_o(data_valid_o), .sat_o(sat_o),
        .load_start_i(load_start), .coef_i(coef), .coef_valid_i(coef_valid),
        .load_active_o(load_active_o), .load_done_o(load_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int sat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int mx[TAPS];
    int mact[TAPS];
    int msh[TAPS];
    int mlmode = 0;   // 0 idle, 1 loading, 2 waiting to commit
    int mptr = 0;
    int free_at = 0;  // first edge at which the core can accept again
    bit m_ovr = 0;
    bit m_done = 0;
    bit m_idle;
    int cbuf[TAPS];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected filter output from the model's delay line and active bank.
    function automatic exp_t model_out(input int c);
        longint acc;
        longint sh;
        exp_t e;
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(mx[k]) * longint'(mact[k]);
        sh = acc >>> SHIFT;
        e.sat = 0;
        if (sh > MAXO) begin
            sh = MAXO;
            e.sat = 1;
        end else if (sh < MINO) begin
            sh = MINO;
            e.sat = 1;
        end
        e.data = int'(sh);
        e.cyc  = c + TAPS + 1;
        return e;
    endfunction

    // Reference model: per-edge behaviour of the filter and coefficient loader.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0;
            for (int k = 0; k < TAPS; k++) begin
                mx[k] = 0;
                msh[k] = 0;
                mact[k] = 0;
            end
            mact[0] = 1 << SHIFT;
            mlmode = 0;
            mptr = 0;
            free_at = 0;
            m_ovr = 0;
            m_done = 0;
            sb.delete();
        end else begin
            cyc++;
            m_idle = (cyc >= free_at);
            m_ovr = 0;
            m_done = 0;
            if (mlmode == 2 && m_idle && !load_start) begin
                mact = msh;
                mlmode = 0;
                m_done = 1;
            end
            if (load_start) begin
                mlmode = 1;
                mptr = 0;
            end else if (mlmode == 1 && coef_valid) begin
                msh[mptr] = int'(coef);
                if (mptr == TAPS - 1) mlmode = 2;
                else mptr++;
            end
            if (sample_valid && en_fir) begin
                if (m_idle) begin
                    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
                    mx[0] = int'(sample);
                    sb.push_back(model_out(cyc));
                    free_at = cyc + TAPS + 2;
                end else begin
                    m_ovr = 1;
                end
            end
        end
    end

    // Monitor: compare the DUT against the model on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("overrun", int'(overrun_o), int'(m_ovr));
            chk("load_done", int'(load_done_o), int'(m_done));
            chk("load_active", int'(load_active_o), int'(mlmode != 0));
            if (data_valid_o) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got data %0d expected no output", int'(data_o));
                end else begin
                    e = sb.pop_front();
                    chk("data", int'(data_o), e.data);
                    chk("sat", int'(sat_o), e.sat);
                    chk("latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input bit sv, input int s, input bit cv, input int c, input bit ls);
        sample_valid = sv;
        sample = DATA_W'(s);
        coef_valid = cv;
        coef = COEF_W'(c);
        load_start = ls;
        @(negedge clk);
        sample_valid = 1'b0;
        coef_valid = 1'b0;
        load_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int v);
        drive(1'b1, v, 1'b0, 0, 1'b0);
    endtask

    // Start pulse followed by n coefficients from cbuf; optional sample alongside coef s_at.
    task automatic load(input int n, input int s_at, input int sval);
        drive(1'b0, 0, 1'b0, 0, 1'b1);
        for (int i = 0; i < n; i++) drive(i == s_at, sval, 1'b1, cbuf[i], 1'b0);
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < TAPS; i++) cbuf[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < TAPS; i++) cbuf[i] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_data"}, int'(data_o), 0);
        chk({tag, "_valid"}, int'(data_valid_o), 0);
        chk({tag, "_sat"}, int'(sat_o), 0);
        chk({tag, "_overrun"}, int'(overrun_o), 0);
        chk({tag, "_load_active"}, int'(load_active_o), 0);
        chk({tag, "_load_done"}, int'(load_done_o), 0);
    endtask

    initial begin
        idle(3);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        en_fir = 1'b1;
        idle(2);

        // Pass-through after reset.
        send(100);
        idle(19);
        chk("passthru_pos", int'(data_o), 100);
        send(-200);
        idle(19);
        chk("passthru_neg", int'({16'h0, data_o}), 32'h0000FF38);

        // Unity-gain taps: impulse response is 16 copies of the impulse.
        fill_const(1024);
        load(TAPS, -1, 0);
        idle(3);
        send(1000);
        idle(19);
        repeat (17) begin
            send(0);
            idle(19);
        end
        chk("impulse_tail", int'(data_o), 0);

        // Full-scale taps drive the output into both clamps.
        fill_const(2047);
        load(TAPS, -1, 0);
        idle(3);
        repeat (20) begin
            send(2047);
            idle(17);
        end
        idle(2);
        chk("sat_pos_data", int'(data_o), 32767);
        chk("sat_pos_flag", int'(sat_o), 1);
        repeat (20) begin
            send(-2048);
            idle(17);
        end
        idle(2);
        chk("sat_neg_data", int'(data_o), -32768);
        chk("sat_neg_flag", int'(sat_o), 1);

        // Overrun: second strobe while the core is busy.
        send(7);
        idle(4);
        send(9);
        idle(25);

        // Aborted partial load, then a fresh full load.
        fill_rand();
        load(10, -1, 0);
        fill_rand();
        load(TAPS, -1, 0);
        idle(3);
        repeat (4) begin
            send(int'($urandom_range(0, 4095)) - 2048);
            idle(19);
        end

        // Load completing while the MAC is busy.
        fill_rand();
        load(TAPS, 10, 300);
        idle(20);
        repeat (3) begin
            send(int'($urandom_range(0, 4095)) - 2048);
            idle(19);
        end

        // Randomized mix of samples, enables, coefficients and restarts.
        for (int i = 0; i < 1500; i++) begin
            en_fir = ($urandom_range(0, 7) != 0);
            drive($urandom_range(0, 5) == 0, int'($urandom_range(0, 4095)) - 2048,
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 4095)) - 2048,
                  $urandom_range(0, 40) == 0);
        end
        en_fir = 1'b1;
        idle(40);

        // Asynchronous reset in the middle of a computation.
        send(500);
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        send(55);
        idle(19);
        chk("after_reset_passthru", int'(data_o), 55);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
